cq_reader: RTL
==============

Name: cq_reader

Overview:
- Consumer-side controller for the 8-entry, 16-bit circular queue: drains a requested number of words and forwards them downstream.
- Drives the queue's `rd` strobe from its `empty` flag and samples the queue's combinational head `dout`.
- Presents words on a valid/ready stream through a 2-entry output buffer, so throughput is one word per cycle.
- Sits between the queue and any downstream sink, for example a serializer or the register-file writer.

Parameters:
- DATA_W, 16, queue word width; must match the queue data width.
- LEN_W, 8, width of the burst-length request; maximum burst is 2^LEN_W-1 words.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  burst request; sampled only in IDLE
- len  input  LEN_W  number of words to drain; sampled with start
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse after the last word of a burst is accepted downstream
- cq_empty  input  1  queue empty flag
- cq_dout  input  DATA_W  queue head data, valid whenever cq_empty=0
- cq_rd  output  1  pop strobe to the queue
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready from the sink
- out_data  output  DATA_W  stream data

Behaviour:
- Reset, asynchronous, reset=0:
  - state=IDLE; pop_left=0, dlv_left=0; buffer count=0.
  - done=0, busy=0, out_valid=0, out_data=0.
  - cq_rd=0 immediately, because it is combinational from reset state.
- Reset mid-burst discards buffered words. Words already popped from the queue are lost; this is the required behaviour.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE, start=1, len!=0: load pop_left=len and dlv_left=len; go to FETCH.
  - IDLE, start=1, len=0: done=1 on the next cycle; stay in IDLE; no pop.
  - FETCH to DRAIN: when pop_left reaches 0 and the buffer is non-empty.
  - FETCH or DRAIN to IDLE: on the out handshake that takes dlv_left to 0. done pulses in the following cycle.
  - start while busy is ignored; len is not re-sampled.
- cq_rd = (state==FETCH) & !cq_empty & (pop_left!=0) & (count<2). It is combinational; no pop is ever issued on empty.
- A pop captures cq_dout into the buffer tail at the same rising edge and decrements pop_left.
- Output buffer: 2-entry FIFO.
  - out_valid = (count!=0); out_data = head entry, driven from registers.
  - A handshake (out_valid & out_ready) retires the head and decrements dlv_left.
  - A pop and a handshake in the same cycle leave count unchanged; data order is preserved.
- Latency: a word present at the queue head while in FETCH appears on out_data one cycle after the pop edge.
- Sustained rate is 1 word/cycle when the queue stays non-empty and out_ready=1.
- Queue empty mid-burst: FETCH waits with cq_rd=0. out_valid continues to reflect buffered words.
- out_ready=0 with count=2: cq_rd=0 until a slot frees.
- out_data holds stable while out_valid=1 and out_ready=0.
- Counters are LEN_W-bit and never underflow; decrements are gated by non-zero.

Optional Feature:
- Macro: CQ_READER_STATS_EN.
- Defined: adds output stall_cnt [15:0].
  - Increments on each FETCH cycle where cq_empty=1 or out_valid&!out_ready.
  - Saturates at 16'hFFFF; clears on reset and on accepted start.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package cq_pkg: CQ_DATA_W=16, CQ_DEPTH=8, CQ_PTR_W=3, and the reader state encoding (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2).
- One sub-module, cq_reader_obuf: the 2-entry output FIFO with push, pop, count, head data.
- The FSM and burst counters stay in cq_reader.

Test Plan:
- Queue preloaded 0x1111,0x2222,0x3333; start, len=3, out_ready=1 -> cq_rd high 3 consecutive cycles; out_data 0x1111,0x2222,0x3333 on 3 consecutive cycles; done one cycle after the last word; busy=0.
- Queue empty; start, len=2; write 0xABCD 5 cycles later, then 0x1234 -> cq_rd stays 0 until cq_empty=0; outputs 0xABCD then 0x1234; done after the second.
- Queue holds 7 words; len=7; out_ready=0 for 10 cycles -> exactly 2 pops, count=2, out_data=first word stable; after out_ready=1, remaining 5 drain in order and done pulses.
- start with len=0 -> no cq_rd, done=1 next cycle; start asserted during a len=4 burst -> ignored, exactly 4 words delivered.
- reset=0 asserted mid-burst after 2 of 5 words -> out_valid, cq_rd, busy drop asynchronously; after release, a new start with len=1 delivers the current queue head.
- With CQ_READER_STATS_EN: len=2, queue empty 4 cycles then filled -> stall_cnt=4 at done; counter absent when the macro is undefined.

Source files
------------

// File: rtl/cq_pkg.sv
// Shared definitions for the circular-queue slice: queue geometry and the
// reader FSM state encoding.
package cq_pkg;

    localparam int CQ_DATA_W = 16;
    localparam int CQ_DEPTH  = 8;
    localparam int CQ_PTR_W  = 3;

    // Reader FSM states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/cq_reader_obuf.sv
// Two-entry output FIFO for cq_reader. Head data comes straight from the
// storage registers, so it holds steady while the sink stalls.
module cq_reader_obuf
    import cq_pkg::*;
#(
    parameter int DATA_W = CQ_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push   = push && (count != 2'd2);
    assign do_pop    = pop && (count != 2'd0);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem    <= '{default: '0};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cq_reader.sv
// Consumer-side burst reader for the 8-entry circular queue. Pops up to
// `len` words and streams them out through a 2-entry buffer.
// Optional: define CQ_READER_STATS_EN to add the stall_cnt output.
module cq_reader
    import cq_pkg::*;
#(
    parameter int DATA_W = CQ_DATA_W,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    input  logic              cq_empty,
    input  logic [DATA_W-1:0] cq_dout,
    output logic              cq_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef CQ_READER_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [1:0]       state;
    logic [LEN_W-1:0] pop_left;
    logic [LEN_W-1:0] dlv_left;
    logic [1:0]       count;
    logic             hs;
    logic             last_hs;

    assign busy      = (state != IDLE);
    assign out_valid = (count != 2'd0);
    assign hs        = out_valid && out_ready;
    assign last_hs   = hs && (dlv_left == ONE);
    assign cq_rd     = (state == FETCH) && !cq_empty && (pop_left != '0) && (count != 2'd2);

    cq_reader_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .push      (cq_rd),
        .push_data (cq_dout),
        .pop       (hs),
        .count     (count),
        .head_data (out_data)
    );

    // Burst FSM and pop/deliver counters; done pulses the cycle after the
    // final handshake (or after a zero-length request).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pop_left <= '0;
            dlv_left <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            pop_left <= len;
                            dlv_left <= len;
                            state    <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH, DRAIN: begin
                    if (cq_rd) begin
                        pop_left <= pop_left - ONE;
                    end
                    if (hs && (dlv_left != '0)) begin
                        dlv_left <= dlv_left - ONE;
                    end
                    // The final pop always leaves the buffer non-empty, so
                    // DRAIN is entered on the edge that issues it.
                    if (last_hs) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if ((state == FETCH) && cq_rd && (pop_left == ONE)) begin
                        state <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CQ_READER_STATS_EN
    // Saturating count of FETCH cycles lost to an empty queue or a stalled sink.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == FETCH) && (cq_empty || (out_valid && !out_ready))
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
